// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter: two byte requesters, one txd line, clock-enable baud timing.
// Define PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_sched #(
    parameter int BAUD_RATE = 9600,
    parameter int FREQ_SYS  = 125000000,
    parameter int DATA_W    = 8
) (
    input  logic              clkSys,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              done,
    output logic              txd
);

    localparam int PERIOD = FREQ_SYS / BAUD_RATE;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PERIOD - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef PARITY_EN
        StParity,
`endif
        StStop
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bitIdx;
    logic [DATA_W-1:0] shiftReg;
    logic              lastServed;
`ifdef PARITY_EN
    logic              parityBit;
`endif

    logic              pick1;
    logic [DATA_W-1:0] winData;
    logic              bitEnd;

    // On a tie, requester 1 wins only if requester 0 was served last.
    assign pick1   = req1 & (~req0 | ~lastServed);
    assign winData = pick1 ? data1 : data0;
    assign bitEnd  = (cnt == CNT_LAST);

    always_ff @(posedge clkSys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            lastServed <= 1'b1;
            txd        <= 1'b1;
            busy       <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done       <= 1'b0;
`ifdef PARITY_EN
            parityBit  <= 1'b0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (state != StIdle) begin
                cnt <= bitEnd ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                StIdle: begin
                    if (req0 | req1) begin
                        state      <= StStart;
                        txd        <= 1'b0;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        shiftReg   <= winData;
                        lastServed <= pick1;
                        gnt0       <= ~pick1;
                        gnt1       <= pick1;
`ifdef PARITY_EN
                        parityBit  <= ^winData;
`endif
                    end
                end
                StStart: begin
                    if (bitEnd) begin
                        state    <= StData;
                        txd      <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitIdx   <= '0;
                    end
                end
                StData: begin
                    if (bitEnd) begin
                        if (bitIdx == IDX_LAST) begin
`ifdef PARITY_EN
                            state <= StParity;
                            txd   <= parityBit;
`else
                            state <= StStop;
                            txd   <= 1'b1;
`endif
                        end else begin
                            txd      <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                            bitIdx   <= bitIdx + IDX_W'(1);
                        end
                    end
                end
`ifdef PARITY_EN
                StParity: begin
                    if (bitEnd) begin
                        state <= StStop;
                        txd   <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    // Registered done must rise one cycle early to land on the final stop cycle.
                    if (cnt == CNT_PRE) begin
                        done <= 1'b1;
                    end
                    if (bitEnd) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: randomized requests against a frame-level reference model.
module tb_uart_tx_sched;

    localparam int P = 16;
`ifdef PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clkSys = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, busy, done, txd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mLast = 1;

    uart_tx_sched #(
        .BAUD_RATE(10),
        .FREQ_SYS (160),
        .DATA_W   (8)
    ) dut (
        .clkSys(clkSys),
        .rst_n (rst_n),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .txd   (txd)
    );

    always #5 clkSys = ~clkSys;
    always @(posedge clkSys) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clkSys);
        #1;
    endtask

    // Expected line bits, index = bit slot in the frame.
    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
`ifdef PARITY_EN
        f[9]  = (ones % 2 == 1);
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
        mLast = 1;
    endtask

    task automatic wait_grant(input int budget, output int which, output int waited);
        which  = -1;
        waited = 0;
        while (which < 0 && waited < budget) begin
            if (gnt0 === 1'b1 && gnt1 === 1'b1) which = 2;
            else if (gnt0 === 1'b1) which = 0;
            else if (gnt1 === 1'b1) which = 1;
            else begin
                tick();
                waited++;
            end
        end
    endtask

    // Observes one frame starting at the grant cycle (c=0) through the first idle cycle.
    task automatic capture_frame(output logic [15:0] first, output logic [15:0] last,
                                 output int doneCount, output int doneAt,
                                 output int extraGnt, output int busyLow, output logic busyEnd);
        first = '0; last = '0; doneCount = 0; doneAt = -1; extraGnt = 0; busyLow = 0;
        busyEnd = 1'bx;
        for (int c = 0; c <= NBITS * P; c++) begin
            if (c < NBITS * P) begin
                if (c % P == 0) first[c/P] = txd;
                if (c % P == P - 1) last[c/P] = txd;
                if (busy !== 1'b1) busyLow++;
            end else begin
                busyEnd = busy;
            end
            if (done === 1'b1) begin
                doneCount++;
                doneAt = c;
            end
            if (c > 0 && (gnt0 === 1'b1 || gnt1 === 1'b1)) extraGnt++;
            if (c < NBITS * P) tick();
        end
    endtask

    task automatic test_reset();
        int dev;
        req0 = 0; req1 = 0; data0 = 0; data1 = 0;
        do_reset(3);
        #1;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({gnt0, gnt1} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1});
        end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        dev = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({txd, busy, gnt0, gnt1, done} !== 5'b10000) dev++;
        end
        total++; if (dev != 0) begin bad++; $display("FAIL reset_idle: got %0d deviations want 0", dev); end
    endtask

    task automatic test_single();
        int which, waited, dc, da, eg, bl;
        logic [15:0] f, l, exp;
        logic be;
        req0 = 1; data0 = 8'hA5;
        exp = frame_bits(8'hA5);
        wait_grant(10, which, waited);
        req0 = 0;
        mLast = 0;
        capture_frame(f, l, dc, da, eg, bl, be);
        total++; if (which !== 0) begin bad++; $display("FAIL single_gnt: got %0d want 0", which); end
        total++; if (f !== exp) begin bad++; $display("FAIL single_bits_first: got %h want %h", f, exp); end
        total++; if (l !== exp) begin bad++; $display("FAIL single_bits_last: got %h want %h", l, exp); end
        total++; if (dc != 1 || da != NBITS * P - 1) begin
            bad++; $display("FAIL single_done: got count %0d at %0d want 1 at %0d", dc, da, NBITS * P - 1);
        end
        total++; if (bl != 0 || be !== 1'b0) begin
            bad++; $display("FAIL single_busy: got lowcycles %0d end %b want 0 0", bl, be);
        end
        total++; if (eg != 0) begin bad++; $display("FAIL single_extra_gnt: got %0d want 0", eg); end
    endtask

    task automatic test_rr();
        int which, waited, dc, da, eg, bl, prev;
        logic [15:0] f, l, exp;
        logic be;
        logic [7:0] d0, d1;
        d0 = 8'($urandom); d1 = 8'($urandom);
        do_reset(2);
        req0 = 1; req1 = 1; data0 = d0; data1 = d1;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(400, which, waited);
            total++; if (which !== k % 2) begin
                bad++; $display("FAIL rr_gnt%0d: got %0d want %0d", k, which, k % 2);
            end
            if (prev >= 0) begin
                total++; if (cyc - prev != NBITS * P + 1) begin
                    bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k, cyc - prev, NBITS * P + 1);
                end
            end
            prev = cyc;
            exp = frame_bits((k % 2 == 0) ? d0 : d1);
            mLast = k % 2;
            capture_frame(f, l, dc, da, eg, bl, be);
            total++; if (f !== exp || l !== exp || dc != 1 || da != NBITS * P - 1) begin
                bad++; $display("FAIL rr_frame%0d: got %h/%h done %0d@%0d want %h done 1@%0d",
                                k, f, l, dc, da, exp, NBITS * P - 1);
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_lone();
        int which, waited, dc, da, eg, bl;
        logic [15:0] f, l, exp;
        logic be;
        req1 = 1; data1 = 8'h3C;
        exp = frame_bits(8'h3C);
        for (int k = 0; k < 3; k++) begin
            wait_grant(400, which, waited);
            mLast = 1;
            capture_frame(f, l, dc, da, eg, bl, be);
            total++; if (which !== 1) begin bad++; $display("FAIL lone_gnt%0d: got %0d want 1", k, which); end
            total++; if (f !== exp || l !== exp || dc != 1 || eg != 0) begin
                bad++; $display("FAIL lone_frame%0d: got %h/%h done %0d extra %0d want %h 1 0",
                                k, f, l, dc, eg, exp);
            end
        end
        req1 = 0;
    endtask

    task automatic test_reset_mid();
        int which, waited, dcount, dc, da, eg, bl;
        logic [15:0] f, l, exp;
        logic be;
        logic [7:0] d;
        do_reset(2);
        req0 = 1; data0 = 8'($urandom);
        wait_grant(10, which, waited);
        req0 = 0;
        dcount = 0;
        for (int i = 0; i < 4 * P + 5; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        rst_n = 0;
        #1;
        total++; if (txd !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_async: got txd %b busy %b want 1 0", txd, busy);
        end
        d = 8'($urandom);
        req0 = 1; data0 = d;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        rst_n = 1;
        mLast = 1;
        wait_grant(10, which, waited);
        total++; if (dcount != 0) begin bad++; $display("FAIL midreset_done: got %0d want 0", dcount); end
        total++; if (which !== 0) begin bad++; $display("FAIL midreset_gnt: got %0d want 0", which); end
        req0 = 0;
        mLast = 0;
        exp = frame_bits(d);
        capture_frame(f, l, dc, da, eg, bl, be);
        total++; if (f !== exp || l !== exp || da != NBITS * P - 1) begin
            bad++; $display("FAIL midreset_frame: got %h/%h done@%0d want %h done@%0d",
                            f, l, da, exp, NBITS * P - 1);
        end
    endtask

    task automatic test_random();
        int which, waited, dc, da, eg, bl, expW;
        logic [15:0] f, l, exp;
        logic be, r0, r1;
        logic [7:0] d0, d1;
        do_reset(2);
        r0 = 0; r1 = 0; d0 = 0; d1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (!r0) begin r0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom); end
            if (!r1) begin r1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom); end
            if (!r0 && !r1) begin r0 = 1; d0 = 8'($urandom); end
            req0 = r0; data0 = d0; req1 = r1; data1 = d1;
            expW = (r0 && r1) ? 1 - mLast : (r1 ? 1 : 0);
            mLast = expW;
            exp = frame_bits(expW == 1 ? d1 : d0);
            wait_grant(10, which, waited);
            if (expW == 1) begin r1 = 0; req1 = 0; end
            else begin r0 = 0; req0 = 0; end
            capture_frame(f, l, dc, da, eg, bl, be);
            total++; if (which !== expW || waited != 1) begin
                bad++; $display("FAIL rand_gnt%0d: got %0d after %0d want %0d after 1",
                                k, which, waited, expW);
            end
            total++; if (f !== exp || l !== exp || dc != 1 || da != NBITS * P - 1
                         || bl != 0 || be !== 1'b0) begin
                bad++; $display("FAIL rand_frame%0d: got %h/%h done %0d@%0d busy %0d/%b want %h",
                                k, f, l, dc, da, bl, be, exp);
            end
        end
        req0 = 0; req1 = 0;
        tick();
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        int which, waited, dc, da, eg, bl;
        logic [15:0] f, l;
        logic be;
        logic [7:0] vals [2];
        logic       par  [2];
        vals[0] = 8'h07; par[0] = 1'b1;
        vals[1] = 8'h03; par[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req0 = 1; data0 = vals[k];
            wait_grant(400, which, waited);
            req0 = 0;
            mLast = 0;
            capture_frame(f, l, dc, da, eg, bl, be);
            total++; if (f[9] !== par[k] || l[9] !== par[k]) begin
                bad++; $display("FAIL parity_bit%0d: got %b want %b", k, f[9], par[k]);
            end
            total++; if (da != 175 || f[10] !== 1'b1) begin
                bad++; $display("FAIL parity_len%0d: got done@%0d stop %b want 175 1", k, da, f[10]);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 0; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
        test_reset();
        test_single();
        test_rr();
        test_lone();
        test_reset_mid();
`ifdef PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
